// File: rtl/ip_pkg.sv
`default_nettype none
// ============================================================================
// Module : ip_pkg
// Shared IPv4 transmit definitions: FSM encodings, header constants and a
// header-word helper used by the transmit path and the checksum feed.
// Rev    : 1.0 - initial release
// ============================================================================
package ip_pkg;

    localparam logic [4:0] S_IDLE         = 5'b00001;
    localparam logic [4:0] S_GEN_CHECKSUM = 5'b00010;
    localparam logic [4:0] S_FOLD         = 5'b00100;
    localparam logic [4:0] S_SEND_WAIT    = 5'b01000;
    localparam logic [4:0] S_IP_SEND      = 5'b10000;

    localparam logic [15:0] IP_HDR_LEN    = 16'd20;
    localparam logic [15:0] UDP_HDR_LEN   = 16'd8;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
    localparam logic [15:0] IP_FLAGS_WORD = 16'h4000;
    localparam logic [7:0]  IP_VER_IHL    = 8'h45;
    localparam logic [3:0]  HDR_LAST_WORD = 4'd9;

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] total_len;
        logic [15:0] id;
    } ip_hdr_t;

    // Word 5 is the checksum slot and reads as zero here.
    function automatic logic [15:0] hdr_word(input ip_hdr_t h, input logic [7:0] ttl,
                                             input logic [3:0] idx);
        logic [15:0] w;
        w = 16'h0000;
        case (idx)
            4'd0:    w = {IP_VER_IHL, 8'h00};
            4'd1:    w = h.total_len;
            4'd2:    w = h.id;
            4'd3:    w = IP_FLAGS_WORD;
            4'd4:    w = {ttl, IP_PROTO_UDP};
            4'd6:    w = h.src[31:16];
            4'd7:    w = h.src[15:0];
            4'd8:    w = h.dst[31:16];
            4'd9:    w = h.dst[15:0];
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ip_checksum.sv
`default_nettype none
// ============================================================================
// Module : ip_checksum
// Sequential 16-bit one's-complement accumulate / double-fold / invert engine.
// Rev    : 1.0 - initial release
// ============================================================================
module ip_checksum (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        valid,
    input  logic        last,
    input  logic [15:0] word,
    output logic        done,
    output logic [15:0] checksum
);

    localparam logic [1:0] P_ACCUM = 2'd0;
    localparam logic [1:0] P_FOLD1 = 2'd1;
    localparam logic [1:0] P_FOLD2 = 2'd2;
    localparam logic [1:0] P_HOLD  = 2'd3;

    logic [19:0] sum_q, sum_d;
    logic [1:0]  phase_q, phase_d;
    logic [15:0] csum_q, csum_d;
    logic [19:0] w_fold;

    assign w_fold = {4'h0, sum_q[15:0]} + {16'h0000, sum_q[19:16]};

    always_comb begin
        sum_d   = sum_q;
        phase_d = phase_q;
        csum_d  = csum_q;
        if (start) begin
            sum_d   = 20'h00000;
            phase_d = P_ACCUM;
        end else begin
            case (phase_q)
                P_ACCUM: begin
                    if (valid) begin
                        sum_d = sum_q + {4'h0, word};
                        if (last) begin
                            phase_d = P_FOLD1;
                        end
                    end
                end
                P_FOLD1: begin
                    sum_d   = w_fold;
                    phase_d = P_FOLD2;
                end
                P_FOLD2: begin
                    // Second fold cannot carry again, so its low half is final.
                    sum_d   = w_fold;
                    csum_d  = ~w_fold[15:0];
                    phase_d = P_HOLD;
                end
                default: begin
                    phase_d = P_HOLD;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= 20'h00000;
            phase_q <= P_ACCUM;
            csum_q  <= 16'h0000;
        end else begin
            sum_q   <= sum_d;
            phase_q <= phase_d;
            csum_q  <= csum_d;
        end
    end

    assign done     = (phase_q == P_FOLD2);
    assign checksum = csum_q;

endmodule
`default_nettype wire

// File: rtl/ip_tx.sv
`default_nettype none
// ============================================================================
// Module : ip_tx
// IPv4 transmit stage: builds the 20-byte header, then streams the UDP bytes.
// Rev    : 1.0 - initial release
// ============================================================================
module ip_tx
    import ip_pkg::*;
#(
    parameter logic [7:0]  TTL         = 8'h80,
    parameter int          UDP_LATENCY = 2,
    parameter int          MIN_IP_LEN  = 46,
    parameter logic [15:0] TIMEOUT     = 16'hffff
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] source_ip_addr,
    input  logic [31:0] destination_ip_addr,
    input  logic [15:0] udp_send_data_length,
    input  logic        ip_tx_req,
    input  logic        ip_data_req,
    output logic        ip_tx_ready,
    output logic [7:0]  ip_tx_data,
    output logic        ip_tx_end,
    output logic        udp_tx_req,
    input  logic        udp_tx_ready,
    output logic        udp_data_req,
    input  logic [7:0]  udp_tx_data
);

    localparam logic [15:0] MIN_LEN     = 16'(MIN_IP_LEN);
    localparam logic [15:0] UDP_REQ_CNT = IP_HDR_LEN - 16'(UDP_LATENCY);

    logic [4:0]  state_q, state_d;
    logic [31:0] src_q, src_d;
    logic [31:0] dst_q, dst_d;
    logic [15:0] total_len_q, total_len_d;
    logic [15:0] send_len_q, send_len_d;
    logic [15:0] id_q, id_d;
    logic [3:0]  gen_cnt_q, gen_cnt_d;
    logic [15:0] wait_q, wait_d;
    logic [15:0] cnt_q, cnt_d;
    logic        ready_q, ready_d;
    logic [7:0]  data_q, data_d;
    logic        end_q, end_d;
    logic        udp_req_q, udp_req_d;

    ip_hdr_t     w_hdr;
    logic [15:0] w_total_len;
    logic [15:0] w_tx_word;
    logic [7:0]  w_hdr_byte;
    logic        ck_start;
    logic        ck_valid;
    logic        ck_last;
    logic [15:0] ck_word;
    logic        ck_done;
    logic [15:0] ck_sum;

    assign w_hdr       = '{src: src_q, dst: dst_q, total_len: total_len_q, id: id_q};
    assign w_total_len = udp_send_data_length + IP_HDR_LEN + UDP_HDR_LEN;

    // Header bytes come out big-endian, two per 16-bit header word.
    assign w_tx_word  = (cnt_q[4:1] == 4'd5) ? ck_sum : hdr_word(w_hdr, TTL, cnt_q[4:1]);
    assign w_hdr_byte = cnt_q[0] ? w_tx_word[7:0] : w_tx_word[15:8];

    assign ck_start = (state_q == S_IDLE) && ip_tx_req;
    assign ck_valid = (state_q == S_GEN_CHECKSUM);
    assign ck_last  = (gen_cnt_q == HDR_LAST_WORD);
    assign ck_word  = hdr_word(w_hdr, TTL, gen_cnt_q);

    ip_checksum u_checksum (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (ck_start),
        .valid    (ck_valid),
        .last     (ck_last),
        .word     (ck_word),
        .done     (ck_done),
        .checksum (ck_sum)
    );

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        total_len_d = total_len_q;
        send_len_d  = send_len_q;
        id_d        = id_q;
        gen_cnt_d   = gen_cnt_q;
        wait_d      = wait_q;
        cnt_d       = cnt_q;
        data_d      = 8'h00;
        end_d       = 1'b0;
        udp_req_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ip_tx_req) begin
                    src_d       = source_ip_addr;
                    dst_d       = destination_ip_addr;
                    total_len_d = w_total_len;
                    send_len_d  = (w_total_len < MIN_LEN) ? MIN_LEN : w_total_len;
                    gen_cnt_d   = 4'd0;
                    udp_req_d   = 1'b1;
                    state_d     = S_GEN_CHECKSUM;
                end
            end
            S_GEN_CHECKSUM: begin
                gen_cnt_d = gen_cnt_q + 4'd1;
                if (ck_last) begin
                    state_d = S_FOLD;
                end
            end
            S_FOLD: begin
                if (ck_done) begin
                    wait_d  = 16'h0000;
                    state_d = S_SEND_WAIT;
                end
            end
            S_SEND_WAIT: begin
                // A ready MAC takes priority over an expiring timeout.
                if (ip_data_req && udp_tx_ready) begin
                    cnt_d   = 16'h0000;
                    state_d = S_IP_SEND;
                end else if (wait_q == TIMEOUT) begin
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            S_IP_SEND: begin
                cnt_d  = cnt_q + 16'd1;
                data_d = (cnt_q < IP_HDR_LEN) ? w_hdr_byte : udp_tx_data;
                if (cnt_q == send_len_q - 16'd1) begin
                    end_d   = 1'b1;
                    id_d    = id_q + 16'd1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_SEND_WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            src_q       <= 32'h0;
            dst_q       <= 32'h0;
            total_len_q <= 16'h0;
            send_len_q  <= 16'h0;
            id_q        <= 16'h0;
            gen_cnt_q   <= 4'h0;
            wait_q      <= 16'h0;
            cnt_q       <= 16'h0;
            ready_q     <= 1'b0;
            data_q      <= 8'h00;
            end_q       <= 1'b0;
            udp_req_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            total_len_q <= total_len_d;
            send_len_q  <= send_len_d;
            id_q        <= id_d;
            gen_cnt_q   <= gen_cnt_d;
            wait_q      <= wait_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            data_q      <= data_d;
            end_q       <= end_d;
            udp_req_q   <= udp_req_d;
        end
    end

    // Combinational so UDP byte 0 lands on udp_tx_data exactly when cnt reaches 20.
    assign udp_data_req = (state_q == S_IP_SEND) && (cnt_q == UDP_REQ_CNT);
    assign ip_tx_ready  = ready_q;
    assign ip_tx_data   = data_q;
    assign ip_tx_end    = end_q;
    assign udp_tx_req   = udp_req_q;

endmodule
`default_nettype wire

// File: doc/ip_tx.md
Name: ip_tx

Overview:
- IPv4 transmit stage directly downstream of the UDP transmit stage.
- On request, computes the 20-byte IPv4 header and its header checksum, then arbitrates the UDP-stage handshake.
- Emits one byte per clock toward the MAC/frame stage: the header, followed by the UDP stream passed through unmodified.
- Pads short frames to the Ethernet minimum payload of 46 bytes.

Parameters:
- TTL, 8'h80, time-to-live byte.
- UDP_LATENCY, 2, cycles from the udp_data_req pulse to UDP byte 0 on udp_tx_data.
- MIN_IP_LEN, 46, minimum bytes sent per packet.
- TIMEOUT, 16'hffff, SEND_WAIT abort count.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- source_ip_addr  in  32  local IP address
- destination_ip_addr  in  32  remote IP address
- udp_send_data_length  in  16  UDP payload bytes (excludes the 8-byte UDP header)
- ip_tx_req  in  1  start pulse from control
- ip_data_req  in  1  MAC ready-for-data
- ip_tx_ready  out  1  header ready, waiting for MAC
- ip_tx_data  out  8  output byte stream
- ip_tx_end  out  1  last-byte strobe
- udp_tx_req  out  1  request pulse to the UDP stage
- udp_tx_ready  in  1  UDP stage waiting
- udp_data_req  out  1  UDP stream start pulse
- udp_tx_data  in  8  UDP byte stream

Behaviour:
- Reset is one clock (clk), asynchronous active-low (rst_n).
- Reset values: all outputs 0; state IDLE; identification counter 0; all counters and accumulators 0. Reset asserted mid-packet aborts immediately.
- States: IDLE -> GEN_CHECKSUM -> FOLD -> SEND_WAIT -> IP_SEND -> IDLE.
- IDLE:
  - On ip_tx_req: latch both addresses and total_len = udp_send_data_length + 28 (16-bit, wraps).
  - Latch send_len = max(total_len, MIN_IP_LEN).
  - Pulse udp_tx_req for 1 cycle (registered, the cycle after the request).
  - Go to GEN_CHECKSUM.
  - ip_tx_req outside IDLE is ignored.
- GEN_CHECKSUM: 10 cycles. Accumulate the header 16-bit words into a 20-bit sum, in order: 4500, total_len, id, 4000, {TTL,8'h11}, 0000, src_hi, src_lo, dst_hi, dst_lo.
- FOLD: 2 cycles.
  - Cycle 1: sum = sum[15:0] + sum[19:16].
  - Cycle 2: repeat the fold, then checksum = ~sum[15:0].
- SEND_WAIT:
  - ip_tx_ready = 1 (registered) while in this state.
  - Advance to IP_SEND when ip_data_req && udp_tx_ready.
  - Wait counter increments each cycle. At TIMEOUT, return to IDLE: id not incremented, no udp_data_req issued.
- IP_SEND:
  - cnt starts at 0 and increments each cycle.
  - ip_tx_data is registered: the byte for cnt=k appears the cycle after cnt==k.
  - cnt 0..19 drive header bytes big-endian: 45, 00, total_len, id, 40, 00, TTL, 11, checksum, src, dst.
  - At cnt == 20-UDP_LATENCY, pulse udp_data_req for 1 cycle.
  - For cnt >= 20, ip_tx_data <= udp_tx_data.
  - ip_tx_end = 1 in the same cycle the final byte (index send_len-1) is on ip_tx_data.
  - At cnt == send_len-1, go to IDLE.
  - id increments (wrapping 16'hffff -> 0) when the packet ends.
- Outside IP_SEND: ip_tx_data = 0.
- The UDP stage handles its own padding to 26 bytes; 20 + 26 = MIN_IP_LEN, so no local zero-fill is needed.
- Simultaneous ip_data_req and TIMEOUT: the send wins.

Decomposition:
- Shared package ip_pkg holds:
  - State one-hot encodings.
  - IP_HDR_LEN = 20, UDP_HDR_LEN = 8.
  - Protocol constant 8'h11.
  - Flags word 16'h4000.
  - Version/IHL byte 8'h45.
- One natural sub-module: ip_checksum, the sequential 16-bit one's-complement accumulate/fold/invert engine with start/word/valid/done handshake, reusable by an ICMP stage.

Test Plan:
- Basic packet: src c0a80002, dst c0a80003, length 32, id 0 -> header 45 00 00 3c 00 00 40 00 80 11 79 5b c0 a8 00 02 c0 a8 00 03.
  - Then 40 UDP bytes, 60 bytes total.
  - udp_data_req pulses at cnt 18; ip_tx_end coincides with byte 59.
- Short payload of 4 -> total_len field 0x0020; 46 bytes sent; bytes 20..45 equal the UDP stream (trailing zeros included); ip_tx_end at byte 45.
- Back-to-back packets -> second header id = 0001 and checksum 795a; a third ip_tx_req during IP_SEND is ignored.
- ip_data_req never asserted -> ip_tx_ready high for 65536 cycles, then state IDLE, id unchanged, udp_data_req never pulses.
- udp_tx_ready held low while ip_data_req is high -> remains in SEND_WAIT; raising udp_tx_ready starts IP_SEND on the next cycle.
- rst_n asserted at byte 25 of a packet -> all outputs 0 immediately; next ip_tx_req produces a correct packet with id 0.
